// File: rtl/user_proto_pkg.sv
// Frame constants, op/error encodings and FSM state type shared by the
// "!"-framed command protocol initiator and its matching parser.
package user_proto;

  localparam logic [7:0] CMD_HDR     = 8'h21;
  localparam logic [7:0] CMD_RD      = 8'h52;
  localparam logic [7:0] CMD_WR      = 8'h57;
  localparam logic [7:0] CMD_VERSION = 8'h56;
  localparam logic [7:0] ACK_WR      = 8'h77;
  localparam logic [7:0] NAK         = 8'h3F;

  localparam logic [1:0] OP_READ    = 2'b00;
  localparam logic [1:0] OP_WRITE   = 2'b01;
  localparam logic [1:0] OP_VERSION = 2'b10;
  localparam logic [1:0] OP_RSVD    = 2'b11;

  localparam logic [1:0] ERR_OK      = 2'd0;
  localparam logic [1:0] ERR_BAD_ACK = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_BAD_OP  = 2'd3;

  localparam logic [31:0] VERSION_LEN = 32'd8;
  localparam int          TMO_W       = 24;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_HDR,
    ST_OP,
    ST_LEN,
    ST_ADDR,
    ST_WDATA,
    ST_WACK,
    ST_RDATA,
    ST_VDATA
  } state_t;

  function automatic logic [7:0] op_char(input logic [1:0] op);
    case (op)
      OP_READ:  return CMD_RD;
      OP_WRITE: return CMD_WR;
      default:  return CMD_VERSION;
    endcase
  endfunction

endpackage

// File: rtl/user_frame_header_shifter.sv
// Holds the outgoing frame header {hdr, op, len, addr} and presents it one
// byte at a time, MSB first; the issuer FSM decides when a byte is taken.
module user_frame_header_shifter
  import user_proto::*;
(
  input  logic        clk,
  input  logic        i_load,
  input  logic [1:0]  i_op,
  input  logic [31:0] i_len,
  input  logic [31:0] i_addr,
  input  logic        i_shift,
  output logic [7:0]  o_byte
);

  logic [79:0] r_sr;

  // Version frames only use the first two bytes, so the tail is zero-filled.
  always_ff @(posedge clk) begin
    if (i_load) begin
      if (i_op == OP_VERSION) r_sr <= {CMD_HDR, CMD_VERSION, 64'd0};
      else                    r_sr <= {CMD_HDR, op_char(i_op), i_len, i_addr};
    end else if (i_shift) begin
      r_sr <= {r_sr[71:0], 8'h00};
    end
  end

  assign o_byte = r_sr[79:72];

endmodule

// File: rtl/user_command_issuer.sv
// Host-side initiator: frames R/W/V commands onto a byte UART and collects
// the read/version data or write acknowledge coming back.
module user_command_issuer
  import user_proto::*;
#(
  parameter int ADDR_BITS      = 32,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_op,
  input  logic [31:0]          cmd_len,
  input  logic [ADDR_BITS-1:0] cmd_addr,
  input  logic [7:0]           wr_data,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  output logic [7:0]           rd_data,
  output logic                 rd_valid,
  output logic [7:0]           uart_txd,
  output logic                 uart_txd_strobe,
  input  logic                 uart_txd_ready,
  input  logic [7:0]           uart_rxd,
  input  logic                 uart_rxd_strobe,
  output logic                 done,
  output logic [1:0]           err_code
);

  state_t             r_state;
  logic [1:0]         r_op;
  logic [31:0]        r_remaining;
  logic [1:0]         r_idx;
  logic [TMO_W-1:0]   r_tmo;

  logic               w_can_send;
  logic               w_accept;
  logic               w_load;
  logic               w_hdr_send;
  logic               w_rem_zero;
  logic               w_tmo_hit;
  logic [7:0]         w_hdr_byte;
  logic [31:0]        w_addr32;

  // The registered strobe blocks can_send for one cycle, which is what keeps
  // strobes at least two cycles apart.
  assign w_can_send = uart_txd_ready && !uart_txd_strobe;
  assign w_accept   = cmd_valid && cmd_ready;
  assign w_load     = w_accept && (cmd_op != OP_RSVD);
  assign w_hdr_send = w_can_send &&
                      (r_state inside {ST_HDR, ST_OP, ST_LEN, ST_ADDR});
  assign w_rem_zero = (r_remaining == 32'd0);
  assign w_tmo_hit  = (r_tmo == TMO_W'(TIMEOUT_CYCLES - 1));
  assign w_addr32   = 32'(cmd_addr);
  assign wr_ready   = (r_state == ST_WDATA) && w_can_send && !w_rem_zero;

  user_frame_header_shifter u_hdr (
    .clk     (clk),
    .i_load  (w_load),
    .i_op    (cmd_op),
    .i_len   (cmd_len),
    .i_addr  (w_addr32),
    .i_shift (w_hdr_send),
    .o_byte  (w_hdr_byte)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state         <= ST_IDLE;
      r_op            <= OP_READ;
      r_remaining     <= 32'd0;
      r_idx           <= 2'd0;
      r_tmo           <= '0;
      cmd_ready       <= 1'b1;
      uart_txd        <= 8'h00;
      uart_txd_strobe <= 1'b0;
      rd_data         <= 8'h00;
      rd_valid        <= 1'b0;
      done            <= 1'b0;
      err_code        <= ERR_OK;
    end else begin
      uart_txd_strobe <= 1'b0;
      rd_valid        <= 1'b0;
      done            <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          r_tmo <= '0;
          if (w_accept) begin
            r_op        <= cmd_op;
            r_remaining <= cmd_len;
            r_idx       <= 2'd0;
            if (cmd_op == OP_RSVD) begin
              done     <= 1'b1;
              err_code <= ERR_BAD_OP;
            end else begin
              r_state   <= ST_HDR;
              cmd_ready <= 1'b0;
            end
          end
        end

        ST_HDR: begin
          if (w_hdr_send) begin
            uart_txd        <= w_hdr_byte;
            uart_txd_strobe <= 1'b1;
            r_state         <= ST_OP;
          end
        end

        ST_OP: begin
          if (w_hdr_send) begin
            uart_txd        <= w_hdr_byte;
            uart_txd_strobe <= 1'b1;
            if (r_op == OP_VERSION) begin
              r_state     <= ST_VDATA;
              r_remaining <= VERSION_LEN;
              r_tmo       <= '0;
            end else begin
              r_state <= ST_LEN;
            end
          end
        end

        ST_LEN: begin
          if (w_hdr_send) begin
            uart_txd        <= w_hdr_byte;
            uart_txd_strobe <= 1'b1;
            r_idx           <= r_idx + 2'd1;
            if (r_idx == 2'd3) r_state <= ST_ADDR;
          end
        end

        ST_ADDR: begin
          if (w_hdr_send) begin
            uart_txd        <= w_hdr_byte;
            uart_txd_strobe <= 1'b1;
            r_idx           <= r_idx + 2'd1;
            if (r_idx == 2'd3) begin
              r_tmo   <= '0;
              r_state <= (r_op == OP_READ) ? ST_RDATA : ST_WDATA;
            end
          end
        end

        ST_WDATA: begin
          if (w_rem_zero) begin
            r_state <= ST_WACK;
            r_tmo   <= '0;
          end else if (wr_valid && wr_ready) begin
            uart_txd        <= wr_data;
            uart_txd_strobe <= 1'b1;
            r_remaining     <= r_remaining - 32'd1;
          end
        end

        ST_WACK: begin
          if (uart_rxd_strobe) begin
            done      <= 1'b1;
            err_code  <= (uart_rxd == ACK_WR) ? ERR_OK : ERR_BAD_ACK;
            r_state   <= ST_IDLE;
            cmd_ready <= 1'b1;
          end else if (w_tmo_hit) begin
            done      <= 1'b1;
            err_code  <= ERR_TIMEOUT;
            r_state   <= ST_IDLE;
            cmd_ready <= 1'b1;
          end else begin
            r_tmo <= r_tmo + TMO_W'(1);
          end
        end

        // A byte arriving on the timeout cycle is taken and restarts the count.
        ST_RDATA, ST_VDATA: begin
          if (w_rem_zero) begin
            done      <= 1'b1;
            err_code  <= ERR_OK;
            r_state   <= ST_IDLE;
            cmd_ready <= 1'b1;
          end else if (uart_rxd_strobe) begin
            rd_data     <= uart_rxd;
            rd_valid    <= 1'b1;
            r_remaining <= r_remaining - 32'd1;
            r_tmo       <= '0;
          end else if (w_tmo_hit) begin
            done      <= 1'b1;
            err_code  <= ERR_TIMEOUT;
            r_state   <= ST_IDLE;
            cmd_ready <= 1'b1;
          end else begin
            r_tmo <= r_tmo + TMO_W'(1);
          end
        end

        default: begin
          r_state   <= ST_IDLE;
          cmd_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_user_command_issuer.sv
// Randomised and directed bench for user_command_issuer against a frame-level
// model of what must go out on the UART and what must come back.
module tb_user_command_issuer;

  localparam int TMO = 100;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [31:0] cmd_len;
  logic [31:0] cmd_addr;
  logic [7:0]  wr_data;
  logic        wr_valid;
  logic        wr_ready;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic [7:0]  uart_txd;
  logic        uart_txd_strobe;
  logic        uart_txd_ready;
  logic [7:0]  uart_rxd;
  logic        uart_rxd_strobe;
  logic        done;
  logic [1:0]  err_code;

  user_command_issuer #(.ADDR_BITS(32), .TIMEOUT_CYCLES(TMO)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_op          (cmd_op),
    .cmd_len         (cmd_len),
    .cmd_addr        (cmd_addr),
    .wr_data         (wr_data),
    .wr_valid        (wr_valid),
    .wr_ready        (wr_ready),
    .rd_data         (rd_data),
    .rd_valid        (rd_valid),
    .uart_txd        (uart_txd),
    .uart_txd_strobe (uart_txd_strobe),
    .uart_txd_ready  (uart_txd_ready),
    .uart_rxd        (uart_rxd),
    .uart_rxd_strobe (uart_rxd_strobe),
    .done            (done),
    .err_code        (err_code)
  );

  initial forever #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int rd_cyc = 0;
  int hold_at = 0;
  logic [1:0] last_err = 2'd0;
  logic prev_strobe = 1'b0;
  logic prev_ready = 1'b1;

  logic [7:0] tx_q[$];
  logic [7:0] rd_q[$];
  logic [7:0] pay[$];
  logic [7:0] rxb[$];
  logic [7:0] exp_tx[$];
  logic [7:0] exp_rd[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    if (uart_txd_strobe) begin
      tx_q.push_back(uart_txd);
      check_eq("tx_back_to_back", 32'(prev_strobe), 32'd0);
      check_eq("tx_without_ready", 32'(prev_ready), 32'd1);
    end
    if (rd_valid) begin
      rd_q.push_back(rd_data);
      rd_cyc = cyc;
    end
    if (done) begin
      done_cnt++;
      last_err = err_code;
      done_cyc = cyc;
      check_eq("cmd_ready_at_done", 32'(cmd_ready), 32'd1);
    end
    prev_strobe = uart_txd_strobe;
    prev_ready  = uart_txd_ready;
  end

  // Transmitter readiness: randomly throttled, with an optional long stall
  // once a given number of frame bytes has gone out.
  initial begin
    uart_txd_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (hold_at > 0 && tx_q.size() >= hold_at) begin
        hold_at = 0;
        uart_txd_ready = 1'b0;
        repeat (20) @(posedge clk);
        #1;
      end
      uart_txd_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic issue_cmd(input logic [1:0] op, input logic [31:0] len, input logic [31:0] addr);
    int k = 0;
    @(negedge clk);
    while (!cmd_ready && k < 500) begin
      @(negedge clk);
      k++;
    end
    check_eq("cmd_ready_wait", 32'(cmd_ready), 32'd1);
    cmd_op = op; cmd_len = len; cmd_addr = addr; cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_op = 2'($urandom); cmd_len = $urandom; cmd_addr = $urandom;
  endtask

  task automatic wait_tx(input int n);
    int k = 0;
    while (tx_q.size() < n && k < 800) begin
      @(negedge clk);
      k++;
    end
    check_eq("tx_wait", 32'(tx_q.size() >= n), 32'd1);
  endtask

  task automatic run_txn(input logic [1:0] op, input int len, input logic [31:0] addr,
                         input int n_rx, input bit inject, input bit stray);
    logic [31:0] lv;
    logic [1:0]  exp_err;
    int need;
    int k;
    lv = 32'(len);
    tx_q.delete(); rd_q.delete(); exp_tx.delete(); exp_rd.delete();
    done_cnt = 0;
    if (op != 2'b11) begin
      exp_tx.push_back(8'h21);
      exp_tx.push_back(op == 2'b00 ? 8'h52 : (op == 2'b01 ? 8'h57 : 8'h56));
    end
    if (op == 2'b00 || op == 2'b01) begin
      for (int i = 3; i >= 0; i--) exp_tx.push_back(lv[8*i +: 8]);
      for (int i = 3; i >= 0; i--) exp_tx.push_back(addr[8*i +: 8]);
    end
    if (op == 2'b01) foreach (pay[i]) exp_tx.push_back(pay[i]);
    need = (op == 2'b10) ? 8 : len;
    exp_err = 2'd3;
    if (op == 2'b00 || op == 2'b10) begin
      for (int i = 0; i < n_rx && i < need; i++) exp_rd.push_back(rxb[i]);
      exp_err = (n_rx >= need) ? 2'd0 : 2'd2;
    end else if (op == 2'b01) begin
      exp_err = (n_rx == 0) ? 2'd2 : ((rxb[0] == 8'h77) ? 2'd0 : 2'd1);
    end

    issue_cmd(op, lv, addr);
    if (inject) begin
      uart_rxd = 8'hEE; uart_rxd_strobe = 1'b1;
      @(posedge clk); #1;
      uart_rxd_strobe = 1'b0;
    end
    if (stray && op != 2'b11) begin
      cmd_valid = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      cmd_valid = 1'b0;
    end
    if (op == 2'b01) begin
      foreach (pay[i]) begin
        wr_data = pay[i]; wr_valid = 1'b1;
        k = 0;
        @(negedge clk);
        while (!wr_ready && k < 800) begin
          @(negedge clk);
          k++;
        end
        check_eq("wr_ready_wait", 32'(wr_ready), 32'd1);
        @(posedge clk); #1;
        wr_valid = 1'b0;
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
      end
    end
    wait_tx(exp_tx.size());
    for (int i = 0; i < n_rx; i++) begin
      repeat ($urandom_range(1, 4)) @(posedge clk);
      #1;
      uart_rxd = rxb[i]; uart_rxd_strobe = 1'b1;
      @(posedge clk); #1;
      uart_rxd_strobe = 1'b0;
    end
    k = 0;
    while (done_cnt == 0 && k < 400) begin
      @(negedge clk);
      k++;
    end
    repeat (3) @(negedge clk);
    check_eq("done_count", 32'(done_cnt), 32'd1);
    check_eq("err_code", 32'(last_err), 32'(exp_err));
    check_eq("tx_count", 32'(tx_q.size()), 32'(exp_tx.size()));
    for (int i = 0; i < exp_tx.size() && i < tx_q.size(); i++)
      check_eq($sformatf("tx_byte%0d", i), 32'(tx_q[i]), 32'(exp_tx[i]));
    check_eq("rd_count", 32'(rd_q.size()), 32'(exp_rd.size()));
    for (int i = 0; i < exp_rd.size() && i < rd_q.size(); i++)
      check_eq($sformatf("rd_byte%0d", i), 32'(rd_q[i]), 32'(exp_rd[i]));
  endtask

  initial begin
    logic [1:0] op;
    int len;
    logic [7:0] b;
    int k;

    reset_n = 1'b0;
    cmd_valid = 1'b0; cmd_op = 2'd0; cmd_len = 32'd0; cmd_addr = 32'd0;
    wr_data = 8'h00; wr_valid = 1'b0;
    uart_rxd = 8'h00; uart_rxd_strobe = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check_eq("rst_strobe", 32'(uart_txd_strobe), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_rd_valid", 32'(rd_valid), 32'd0);
    check_eq("rst_wr_ready", 32'(wr_ready), 32'd0);
    check_eq("rst_err", 32'(err_code), 32'd0);
    reset_n = 1'b1;

    // Read, len 3, addr 0x1234
    pay.delete(); rxb = '{8'hAA, 8'hBB, 8'hCC};
    run_txn(2'b00, 3, 32'h1234, 3, 1'b0, 1'b0);

    // Write with good and bad acknowledge
    pay = '{8'hDE, 8'hAD}; rxb = '{8'h77};
    run_txn(2'b01, 2, 32'h10, 1, 1'b0, 1'b0);
    rxb = '{8'h3F};
    run_txn(2'b01, 2, 32'h10, 1, 1'b0, 1'b0);

    // Version with a stray rx byte during the header
    pay.delete(); rxb.delete();
    for (int i = 0; i < 8; i++) rxb.push_back(8'h31);
    run_txn(2'b10, 0, 32'h0, 8, 1'b1, 1'b0);

    // Read timeout after one byte
    rxb = '{8'h5A};
    run_txn(2'b00, 2, 32'hCAFE_0001, 1, 1'b0, 1'b0);
    check_eq("timeout_latency", 32'(done_cyc - rd_cyc), 32'(TMO));

    // Write acknowledge never arrives
    pay = '{8'h42}; rxb.delete();
    run_txn(2'b01, 1, 32'h0000_0400, 0, 1'b0, 1'b0);

    // Long transmitter stall after the fourth byte
    pay.delete(); rxb = '{8'h11, 8'h22};
    tx_q.delete();
    hold_at = 4;
    run_txn(2'b00, 2, 32'h8765_4321, 2, 1'b0, 1'b0);

    // Reserved op, read of length zero
    run_txn(2'b11, 5, 32'h1, 0, 1'b0, 1'b0);
    rxb.delete();
    run_txn(2'b00, 0, 32'h0BAD_F00D, 0, 1'b0, 1'b0);

    // Reset in the middle of the address bytes
    tx_q.delete();
    issue_cmd(2'b00, 32'd3, 32'hA5A5_5A5A);
    k = 0;
    while (tx_q.size() < 7 && k < 400) begin
      @(negedge clk);
      k++;
    end
    check_eq("mid_addr_reached", 32'(tx_q.size() >= 7), 32'd1);
    reset_n = 1'b0;
    #1;
    check_eq("areset_cmd_ready", 32'(cmd_ready), 32'd1);
    check_eq("areset_strobe", 32'(uart_txd_strobe), 32'd0);
    check_eq("areset_txd", 32'(uart_txd), 32'd0);
    check_eq("areset_done", 32'(done), 32'd0);
    check_eq("areset_wr_ready", 32'(wr_ready), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    rxb = '{8'h01, 8'h02, 8'h03};
    run_txn(2'b00, 3, 32'h0000_0077, 3, 1'b0, 1'b0);

    // Randomised commands
    for (int t = 0; t < 16; t++) begin
      op = 2'($urandom_range(0, 3));
      if (op == 2'b11 && $urandom_range(0, 1) == 0) op = 2'b00;
      len = $urandom_range(0, 5);
      pay.delete(); rxb.delete();
      if (op == 2'b01) begin
        for (int i = 0; i < len; i++) pay.push_back(8'($urandom));
        b = 8'($urandom);
        if ($urandom_range(0, 1) == 0) b = 8'h77;
        rxb.push_back(b);
      end else begin
        for (int i = 0; i < 8; i++) rxb.push_back(8'($urandom));
      end
      run_txn(op, len, $urandom, (op == 2'b01) ? 1 : ((op == 2'b10) ? 8 : len),
              1'($urandom), 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/user_command_issuer.md
Name: user_command_issuer

Overview:
- Initiator end of the "!"-framed serial command protocol: builds and sends R/W/V frames over a byte UART, then collects the responses.
- Used as the host-side driver where one FPGA drives a remote spispy's command parser (board-to-board link, loopback self-test).
- A local master supplies one command at a time plus a write-data byte stream. It receives read/version bytes as strobes and a done/error completion.

Parameters:
ADDR_BITS, 32, width of cmd_addr; zero-extended to 32 bits on the wire, MSB first
TIMEOUT_CYCLES, 1000000, response-idle cycles before aborting (counter 24 bits)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous, active-low reset
cmd_valid  in  1  command request
cmd_ready  out  1  high only in IDLE; accepted on cmd_valid&&cmd_ready
cmd_op  in  2  00 read, 01 write, 10 version, 11 reserved
cmd_len  in  32  byte count (ignored for version)
cmd_addr  in  ADDR_BITS  start byte address
wr_data  in  8  write payload byte
wr_valid  in  1  payload byte valid
wr_ready  out  1  payload byte consumed this cycle when wr_valid&&wr_ready
rd_data  out  8  returned byte (read data or version char)
rd_valid  out  1  one-cycle strobe; no backpressure
uart_txd  out  8  byte to transmitter
uart_txd_strobe  out  1  one-cycle send pulse
uart_txd_ready  in  1  transmitter can accept a byte
uart_rxd  in  8  received byte
uart_rxd_strobe  in  1  received byte valid
done  out  1  one-cycle completion strobe
err_code  out  2  valid with done: 0 OK, 1 BAD_ACK, 2 TIMEOUT, 3 BAD_OP

Behaviour:
- Reset (async assert, sync release): state IDLE. All outputs 0 except cmd_ready=1. Counters cleared. Any partial frame is abandoned and no further byte is sent.
- TX pacing: can_send = uart_txd_ready && !uart_txd_strobe. At most one strobe per two cycles. uart_txd is held stable while the strobe is high.
- States: IDLE, HDR, OP, LEN, ADDR, WDATA, WACK, RDATA, VDATA.
- IDLE:
  - On accept, latch op, len and addr.
  - Ops 00/01/10 go to HDR.
  - Op 11 sends no bytes and pulses done with err BAD_OP on the next cycle, staying in IDLE.
- HDR: sends "!" (0x21). OP: sends "R"/"W"/"V". First strobe is at the earliest cycle after accept in which can_send holds.
- Version: goes directly from OP to VDATA with remaining=8; no LEN/ADDR bytes.
- LEN / ADDR:
  - Four bytes each, MSB first. A 2-bit byte index wraps 3→0 on state change.
  - After ADDR: read goes to RDATA, write goes to WDATA.
- WDATA:
  - wr_ready = can_send && remaining!=0. On handshake, uart_txd<=wr_data, strobe=1 the next cycle, remaining-1.
  - remaining==0, including len 0, goes to WACK.
- WACK:
  - First rx byte 'w' (0x77): done with OK.
  - Any other rx byte: done with BAD_ACK.
  - Either way, return to IDLE.
- RDATA / VDATA:
  - Each uart_rxd_strobe gives rd_data=uart_rxd and rd_valid=1 on the next cycle, remaining-1.
  - remaining==0 gives done OK and IDLE.
  - Read with len 0 completes on the cycle after the last address byte.
- Rx bytes arriving in IDLE/HDR/OP/LEN/ADDR/WDATA are discarded.
- Timeout:
  - The counter clears on entering WACK/RDATA/VDATA and on every rx strobe. It increments otherwise in those states.
  - Reaching TIMEOUT_CYCLES gives done with TIMEOUT and IDLE.
  - If an rx strobe and the timeout coincide, the byte wins and the counter clears.
- Arithmetic: remaining is a 32-bit down-counter and never decrements below 0. Addresses are not incremented locally; the remote side auto-increments.
- cmd_valid outside IDLE is ignored; done and cmd_ready return to 1 on the same cycle.

Decomposition:
- Shared package user_proto holds:
  - frame constants CMD_HDR "!", CMD_RD "R", CMD_WR "W", CMD_VERSION "V", ACK_WR "w", NAK "?";
  - OP_* encodings;
  - ERR_* codes.
- The parser block imports the same constants.
- One natural sub-module: user_frame_header_shifter, which loads {hdr, op, len, addr} as a 10-byte (or 2-byte for V) shift register and emits bytes under can_send.

Test Plan:
- Read, len 3, addr 0x1234 → tx 21 52 00 00 00 03 00 00 12 34. Rx AA BB CC → rd_valid ×3 with AA, BB, CC, then done with err 0.
- Write, len 2, addr 0x10, payload DE AD → tx 21 57 00 00 00 02 00 00 00 10 DE AD. Rx 0x77 → done OK. Repeat with rx 0x3F → err 1.
- Version → tx 21 56 only. Rx eight 0x31 → 8 rd_valid, done OK. Rx bytes injected during header are dropped.
- TIMEOUT_CYCLES=100, read len 2, supply one byte → done with err 2 exactly 100 cycles after that byte.
- Hold uart_txd_ready low 20 cycles after byte 4 → no strobes; byte sequence resumes intact; no back-to-back strobes anywhere. Op 11 → done with err 3, zero tx.
- Assert reset_n low mid-ADDR → all outputs clear immediately; after release cmd_ready=1 and the next command starts with 0x21.
